// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - ALU instruction sequencer with 8x8 register file; optional MULTIPLY high-byte writeback under macro ALU_SEQ_MUL_HIGH_WB_EN
module alu_sequencer #(
  parameter logic [3:0] SREG_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_op,
  input  logic [2:0] in_rd,
  input  logic [2:0] in_rs,
  input  logic       ld_en,
  input  logic [2:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_fsl,
  input  logic [7:0] alu_result,
  input  logic [7:0] alu_mul_high,
  input  logic [3:0] alu_sreg,
  output logic [3:0] sreg,
  output logic       done,
  input  logic [2:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam logic [3:0] OP_MUL = 4'b1110;
  localparam logic [3:0] OP_CMP = 4'b1111;

`ifdef ALU_SEQ_MUL_HIGH_WB_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WBH = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1} state_t;
`endif

  state_t     state;
  state_t     state_nxt;
  logic [7:0] rf [8];
  logic [3:0] op_q;
  logic [2:0] rd_q;
  logic [2:0] rs_q;
  logic       accept;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       sreg_we;
  logic       done_nxt;
  logic       mul_cap;

`ifdef ALU_SEQ_MUL_HIGH_WB_EN
  logic [7:0] mul_hi_q;
`else
  logic       unused_mul_high;
  assign unused_mul_high = ^alu_mul_high;
`endif

  assign dbg_data = rf[dbg_addr];

  // Next-state, ALU drive and register-file write selection for the current state
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    alu_fsl   = 4'b0000;
    accept    = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = ld_addr;
    rf_wdata  = ld_data;
    sreg_we   = 1'b0;
    done_nxt  = 1'b0;
    mul_cap   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        rf_we    = ld_en;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        alu_a    = rf[rd_q];
        alu_b    = rf[rs_q];
        alu_fsl  = op_q;
        rf_we    = (op_q != OP_CMP);
        rf_waddr = rd_q;
        rf_wdata = alu_result;
        sreg_we  = 1'b1;
`ifdef ALU_SEQ_MUL_HIGH_WB_EN
        if (op_q == OP_MUL) begin
          mul_cap   = 1'b1;
          state_nxt = WBH;
        end else begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
`else
        done_nxt  = 1'b1;
        state_nxt = IDLE;
`endif
      end
`ifdef ALU_SEQ_MUL_HIGH_WB_EN
      WBH: begin
        rf_we     = 1'b1;
        rf_waddr  = rd_q + 3'd1;
        rf_wdata  = mul_hi_q;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Instruction latch, register file, status register and retirement pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= 4'b0000;
      rd_q <= 3'd0;
      rs_q <= 3'd0;
      sreg <= SREG_RST;
      done <= 1'b0;
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
    end else begin
      done <= done_nxt;
      if (accept) begin
        op_q <= in_op;
        rd_q <= in_rd;
        rs_q <= in_rs;
      end
      if (sreg_we) sreg <= alu_sreg;
      if (rf_we) rf[rf_waddr] <= rf_wdata;
    end
  end

`ifdef ALU_SEQ_MUL_HIGH_WB_EN
  // Holds the multiply high byte between EXEC and WBH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mul_hi_q <= 8'h00;
    else if (mul_cap) mul_hi_q <= alu_mul_high;
  end
`else
  logic unused_mul_cap;
  assign unused_mul_cap = mul_cap;
`endif

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter SREG_RST, default 4'b0000: reset value of architectural status register {V,S,C,Z}.
REQ-002 SHALL have clk input 1: single clock; all state updates on rising edge.
REQ-003 SHALL have rst_n input 1: reset, asynchronous and active-low.
REQ-004 SHALL have in_valid input 1: instruction offered.
REQ-005 SHALL have in_ready output 1: sequencer accepts instruction this cycle.
REQ-006 SHALL have in_op input 4: ALU opcode (ADD=0000 .. COMPARE=1111).
REQ-007 SHALL have in_rd input 3: destination register, also operand A source.
REQ-008 SHALL have in_rs input 3: operand B source register.
REQ-009 SHALL have ld_en, ld_addr, ld_data inputs 1, 3, 8: register-file preload port.
REQ-010 SHALL have alu_a, alu_b, alu_fsl outputs 8, 8, 4: drive ALU A, B, fsl.
REQ-011 SHALL have alu_result, alu_mul_high, alu_sreg inputs 8, 8, 4: ALU outputs.
REQ-012 SHALL have sreg output 4: architectural status register {V,S,C,Z}.
REQ-013 SHALL have done output 1: one-cycle pulse on instruction retirement.
REQ-014 SHALL have dbg_addr input 3 and dbg_data output 8: combinational register-file read.

Function
REQ-015 SHALL hold an 8x8-bit register file R0..R7 and a 4-bit sreg register.
REQ-016 SHALL implement states IDLE, EXEC, WBH; in_ready = 1 only in IDLE.
REQ-017 IDLE: on in_valid & in_ready, SHALL latch op/rd/rs and go to EXEC at the same edge.
REQ-018 EXEC: alu_a = R[rd], alu_b = R[rs], alu_fsl = op, all stable for the whole cycle.
REQ-019 EXEC end edge: op != COMPARE -> R[rd] <= alu_result; COMPARE -> no register write.
REQ-020 EXEC end edge: sreg <= alu_sreg for every opcode.
REQ-021 EXEC end edge: op == MULTIPLY with macro enabled -> capture alu_mul_high, go to WBH; else go to IDLE.
REQ-022 WBH: R[(rd+1) mod 8] <= captured mul_high, then go to IDLE; rd = 7 wraps to R0.
REQ-023 done SHALL be registered, high exactly one cycle after the final write edge (EXEC or WBH).
REQ-024 Latency: accept edge k -> writeback edge k+1 -> done high in cycle k+1..k+2; MULTIPLY with WBH adds one cycle.
REQ-025 Throughput: next instruction can be accepted in the cycle done is high.
REQ-026 In IDLE, alu_a/alu_b SHALL be 0 and alu_fsl SHALL be 4'b0000.
REQ-027 ld_en SHALL write R[ld_addr] <= ld_data only in IDLE; it is ignored in EXEC/WBH.
REQ-028 ld_en coincident with acceptance: load takes effect and EXEC reads the loaded value.
REQ-029 rd == rs SHALL be legal; both operands read the same register.
REQ-030 ADDC/SUBC carry-in SHALL come from the ALU's own SREG path; the sequencer supplies no carry.

Reset
REQ-031 rst_n low SHALL force state IDLE, R0..R7 = 0, sreg = SREG_RST, done = 0, latched op/rd/rs = 0, immediately and regardless of clk.
REQ-032 Reset mid-EXEC or mid-WBH SHALL abort the instruction with no writeback and no done pulse.
REQ-033 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-034 Macro ALU_SEQ_MUL_HIGH_WB_EN defined: MULTIPLY uses WBH and writes the high byte to R[(rd+1) mod 8].
REQ-035 Macro undefined: no WBH state, MULTIPLY retires from EXEC, high byte discarded, alu_mul_high unused.

Verification
REQ-036 Load R1=0x05, R2=0x03; ADD rd=1 rs=2 -> R1=0x08, sreg Z=0, done at accept+2 cycles.
REQ-037 Load R3=0x10; COMPARE rd=3 rs=3 -> R3 unchanged, sreg = model alu_sreg, done pulses once.
REQ-038 Macro on: load R7=0x10, R0=0x20; MULTIPLY rd=7 rs=0 -> R7=0x00, R0=0x02, done at accept+3.
REQ-039 Hold in_valid for back-to-back ADDs -> one accept per 2 cycles, in_ready low during EXEC.
REQ-040 Assert rst_n low during EXEC of ADD rd=1 -> R1=0, no done, in_ready=1 after release.
REQ-041 ld_en with ld_addr=4 during EXEC -> R4 unchanged; same load in IDLE -> R4 = ld_data.
